// File: rtl/goomba_spawner.sv
// goomba_spawner: spawn controller for a bank of goomba slots.
//
// Tracks the level scroll column from Shift pulses and walks a synchronous
// spawn-table ROM of (column, ground Y) entries. When the scroll reaches an
// entry's column, the lowest-index free slot gets a one-cycle start pulse with
// spawnX/spawnY. level_start clears every slot and restarts the table walk;
// any slot's kill_Mario latches a sticky mario_hit that halts spawning.
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   level_start         one-cycle pulse, (re)start the level
//   Shift               one-cycle pulse per scrolled tile column
//   Goomba_alive        per-slot alive status
//   Goomba_kill_Mario   per-slot "killed Mario" status
//   rom_addr            spawn-table read address
//   rom_col/rom_y/rom_entry_valid  table entry, valid 1 Clk after rom_addr
//   start, kill         per-slot one-cycle spawn / clear pulses
//   spawnX, spawnY      spawn position for the slot being started
//   scroll_col          current scroll column (saturating)
//   mario_hit           sticky hit flag for this level
//   table_done          table exhausted or end marker reached
module goomba_spawner #(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned TABLE_DEPTH = 16,
    parameter logic [9:0]  SPAWN_X     = 10'd519,
    parameter int unsigned COL_W       = 8,
    localparam int unsigned AW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 level_start,
    input  logic                 Shift,
    input  logic [NUM_SLOTS-1:0] Goomba_alive,
    input  logic [NUM_SLOTS-1:0] Goomba_kill_Mario,
    output logic [AW-1:0]        rom_addr,
    input  logic [COL_W-1:0]     rom_col,
    input  logic [9:0]           rom_y,
    input  logic                 rom_entry_valid,
    output logic [NUM_SLOTS-1:0] start,
    output logic [NUM_SLOTS-1:0] kill,
    output logic [9:0]           spawnX,
    output logic [9:0]           spawnY,
    output logic [COL_W-1:0]     scroll_col,
    output logic                 mario_hit,
    output logic                 table_done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StCheck,
        StIssue,
        StHalt,
        StDone
    } state_e;

    localparam logic [COL_W-1:0] COL_MAX  = {COL_W{1'b1}};
    localparam logic [AW-1:0]    PTR_LAST = AW'(TABLE_DEPTH - 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [AW-1:0]        rom_addr_q, rom_addr_d;
    logic [NUM_SLOTS-1:0] start_q, start_d;
    logic [NUM_SLOTS-1:0] kill_q, kill_d;
    logic [9:0]           spawn_x_q, spawn_x_d;
    logic [9:0]           spawn_y_q, spawn_y_d;
    logic [COL_W-1:0]     scroll_col_q, scroll_col_d;
    logic                 mario_hit_q, mario_hit_d;
    logic                 table_done_q, table_done_d;

    logic [NUM_SLOTS-1:0] free_onehot;
    logic                 free_any;
    logic                 mario_set;

    // Lowest clear bit of the alive vector, as a one-hot.
    assign free_onehot = ~Goomba_alive & (Goomba_alive + NUM_SLOTS'(1));
    assign free_any    = |free_onehot;
    assign mario_set   = (|Goomba_kill_Mario) && !mario_hit_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rom_addr_d   = rom_addr_q;
        start_d      = '0;
        kill_d       = '0;
        spawn_x_d    = spawn_x_q;
        spawn_y_d    = spawn_y_q;
        table_done_d = table_done_q;
        mario_hit_d  = mario_hit_q | (|Goomba_kill_Mario);
        scroll_col_d = scroll_col_q;

        if (Shift && (scroll_col_q != COL_MAX)) begin
            scroll_col_d = scroll_col_q + COL_W'(1);
        end

        case (state_q)
            StIdle: ;
            StFetch: begin
                rom_addr_d = ptr_q;
                state_d    = StWait;
            end
            StWait: state_d = StCheck;
            StCheck: begin
                if (!rom_entry_valid) begin
                    table_done_d = 1'b1;
                    state_d      = StDone;
                end else if ((rom_col <= scroll_col_q) && free_any) begin
                    // Due entry waits here until a slot frees; never dropped.
                    start_d   = free_onehot;
                    spawn_x_d = SPAWN_X;
                    spawn_y_d = rom_y;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (ptr_q == PTR_LAST) begin
                    table_done_d = 1'b1;
                    state_d      = StDone;
                end else begin
                    ptr_d   = ptr_q + AW'(1);
                    state_d = StFetch;
                end
            end
            StHalt: ;
            StDone: ;
            default: state_d = StIdle;
        endcase

        // A pulse already on the outputs in ISSUE finishes; nothing new starts.
        if (mario_set && (state_q != StIdle)) begin
            state_d      = StHalt;
            start_d      = '0;
            ptr_d        = ptr_q;
            rom_addr_d   = rom_addr_q;
            spawn_x_d    = spawn_x_q;
            spawn_y_d    = spawn_y_q;
            table_done_d = table_done_q;
        end

        if (level_start) begin
            state_d      = StFetch;
            ptr_d        = '0;
            start_d      = '0;
            kill_d       = '1;
            mario_hit_d  = 1'b0;
            table_done_d = 1'b0;
            scroll_col_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            rom_addr_q   <= '0;
            start_q      <= '0;
            kill_q       <= '0;
            spawn_x_q    <= '0;
            spawn_y_q    <= '0;
            scroll_col_q <= '0;
            mario_hit_q  <= 1'b0;
            table_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rom_addr_q   <= rom_addr_d;
            start_q      <= start_d;
            kill_q       <= kill_d;
            spawn_x_q    <= spawn_x_d;
            spawn_y_q    <= spawn_y_d;
            scroll_col_q <= scroll_col_d;
            mario_hit_q  <= mario_hit_d;
            table_done_q <= table_done_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign start      = start_q;
    assign kill       = kill_q;
    assign spawnX     = spawn_x_q;
    assign spawnY     = spawn_y_q;
    assign scroll_col = scroll_col_q;
    assign mario_hit  = mario_hit_q;
    assign table_done = table_done_q;

endmodule

// File: doc/goomba_spawner.md
Name: goomba_spawner

Overview:
Upstream controller for the bank of goomba instances. It tracks level scroll position from Shift pulses and walks a synchronous spawn-table ROM of (column, ground Y) entries. When the scroll reaches an entry's column, it issues a one-cycle start pulse with spawnX/spawnY to the lowest-index free goomba slot. It also clears all slots on level start and latches a Mario-hit flag from any slot's kill_Mario.

Parameters:
NUM_SLOTS, 4, number of goomba instances driven (start/kill/alive vector width)
TABLE_DEPTH, 16, number of spawn-table entries; rom_addr width = clog2(TABLE_DEPTH)
SPAWN_X, 10'd519, X coordinate given to every spawned goomba (right play-field edge)
COL_W, 8, width of scroll column counter and rom_col

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
level_start  in  1  one-Clk pulse: (re)start level
Shift  in  1  one-Clk pulse per 40 px screen scroll (one tile column)
Goomba_alive  in  NUM_SLOTS  isAlive_out of each goomba slot
Goomba_kill_Mario  in  NUM_SLOTS  kill_Mario of each goomba slot
rom_addr  out  clog2(TABLE_DEPTH)  spawn-table read address
rom_col  in  COL_W  entry scroll column; valid 1 Clk after rom_addr
rom_y  in  10  entry ground Y (goomba spawnY); valid 1 Clk after rom_addr
rom_entry_valid  in  1  0 = end-of-table marker; valid 1 Clk after rom_addr
start  out  NUM_SLOTS  one-hot, one-cycle spawn pulse per slot
kill  out  NUM_SLOTS  one-cycle clear pulse per slot
spawnX  out  10  spawn X for the slot being started
spawnY  out  10  spawn Y for the slot being started
scroll_col  out  COL_W  current scroll column
mario_hit  out  1  sticky: some goomba killed Mario this level
table_done  out  1  all table entries consumed or end marker reached

Behaviour:
- Reset (async) values: FSM=IDLE, ptr=0, rom_addr=0, scroll_col=0, start=0, kill=0, spawnX=0, spawnY=0, mario_hit=0, table_done=0.
- All outputs are registered.
- scroll_col: +1 on each Shift; saturates at 2^COL_W-1; cleared by level_start. Simultaneous Shift and level_start: level_start wins, scroll_col=0.
- level_start in any state, at the next edge: ptr=0, mario_hit=0, table_done=0, start=0, kill=all ones for exactly one cycle, FSM -> FETCH.
- FSM states: IDLE, FETCH, WAIT, CHECK, ISSUE, HALT, DONE.
  - IDLE: outputs quiet; leaves only on level_start.
  - FETCH: rom_addr<=ptr -> WAIT.
  - WAIT: one cycle for ROM latency -> CHECK.
  - CHECK:
    - rom_entry_valid=0 -> DONE.
    - rom_col > scroll_col -> stay in CHECK (re-evaluated each cycle as scroll_col changes).
    - rom_col <= scroll_col and some Goomba_alive bit is 0 -> latch slot = lowest index with alive=0, latch spawnY=rom_y, spawnX=SPAWN_X -> ISSUE.
    - Due entry but all slots alive -> stay in CHECK until a slot frees; entry is never dropped.
  - ISSUE: start[slot]=1 for one cycle; spawnX/spawnY held stable that cycle and afterwards until the next ISSUE. Then:
    - ptr == TABLE_DEPTH-1 -> DONE.
    - otherwise ptr+1 -> FETCH.
    - Minimum 3 cycles between consecutive start pulses (FETCH, WAIT, CHECK), so the spawned slot's alive is visible before the next slot search.
  - DONE: table_done=1; idle until level_start.
  - HALT: no spawns; idle until level_start.
- Entries whose column has already passed are spawned immediately, back-to-back at the 3-cycle cadence.
- mario_hit: set on the cycle after any Goomba_kill_Mario bit is 1; sticky until level_start or Reset. When mario_hit sets, FSM -> HALT from any state except IDLE. An ISSUE occurring in that same cycle still completes its start pulse.
- start and kill are never asserted in the same cycle.

Test Plan:
- Reset mid-ISSUE: assert Reset while start=0010 -> start, kill, spawnX, spawnY, scroll_col, mario_hit all 0 immediately; FSM IDLE.
- Table {col 0,y 400},{col 2,y 360},end; pulse level_start -> kill=1111 for 1 cycle, then start=0001 with spawnX=519, spawnY=400. Send 2 Shift pulses -> scroll_col=2 and start=0010 with spawnY=360; then table_done=1.
- All 4 slots alive with entry col 0 due -> no start pulse. Drop Goomba_alive[2] -> start=0100 on the next CHECK->ISSUE, within 2 cycles.
- Three entries all at col 0 with all slots free -> start=0001, 0010, 0100, each one cycle, spaced exactly 4 cycles apart.
- Goomba_kill_Mario=0100 -> mario_hit=1 next cycle; later-due entries produce no start; level_start clears mario_hit and restarts at ptr=0.
- Shift and level_start in the same cycle at scroll_col=5 -> scroll_col=0. 300 Shift pulses with COL_W=8 -> scroll_col saturates at 255.
